clip_timer: RTL
===============

// Module: clip_timer
// PURPOSE
//  Two-second clip timer and sample address generator for the record/playback path.
//  Runs while the controller's timer enable is high: produces a one-cycle sample strobe
//  and a sample memory address for the serializer/deserializer, then pulses seconds2
//  back to the controller once the clip length has elapsed.
// PARAMETERS
//  CLK_HZ     50_000_000  system clock frequency in Hz
//  SAMPLE_HZ  8_000       sample strobe rate in Hz; CLK_HZ % SAMPLE_HZ == 0 required
//  CLIP_SEC   2           clip length in seconds
//  (derived)  DIV = CLK_HZ/SAMPLE_HZ (must be >= 2); DEPTH = SAMPLE_HZ*CLIP_SEC;
//             ADDR_W = $clog2(DEPTH). Elaboration error if any constraint fails.
// PORTS
//  clock        in   1       system clock; all logic on posedge
//  reset_n      in   1       synchronous reset, active low
//  timer        in   1       run enable from controller (level, high during s1..s4)
//  sample_tick  out  1       one-cycle strobe; addr is valid for this sample
//  addr         out  ADDR_W  sample index into clip memory, 0..DEPTH-1
//  seconds2     out  1       one-cycle pulse: clip complete
//  busy         out  1       high whenever state != IDLE
// BEHAVIOUR
//  - One clock, one synchronous active-low reset. Reset (reset_n==0 at an edge):
//    state=IDLE, presc=0, addr=0; sample_tick=0, seconds2=0, busy=0. Reset wins over all.
//  - All outputs decode from registers only (no combinational path from timer).
//  - FSM states: IDLE, RUN, DONE, HOLD.
//    IDLE: presc=0, addr=0. timer==1 -> RUN (presc=0, addr=0).
//    RUN: presc counts 0..DIV-1, then wraps. sample_tick = (presc==DIV-1).
//         On a tick with addr<DEPTH-1: addr+1. On a tick with addr==DEPTH-1 -> DONE.
//         timer==0 at any edge in RUN -> IDLE (abort). A tick present that cycle still
//         fires, but seconds2 never follows. Abort takes priority over entering DONE.
//    DONE: seconds2=1 for exactly this cycle. timer==1 -> HOLD; timer==0 -> IDLE.
//    HOLD: all strobes 0. Stay until timer==0, then -> IDLE. No re-arm while high.
//  - Latency: timer sampled high at edge E0 -> first tick DIV cycles later (addr 0).
//    Tick k (addr k) occurs at cycle (k+1)*DIV after E0. seconds2 occurs at cycle
//    DEPTH*DIV+1. addr holds DEPTH-1 in DONE/HOLD and returns to 0 in IDLE.
//  - Handshake with controller: the controller samples seconds2 and leaves s1..s4 on the
//    next edge, so timer falls one cycle after seconds2. HOLD absorbs any longer delay.
//  - Re-trigger: a new run needs timer low for >=1 cycle (IDLE) and then high again.
//  - The presc width is $clog2(DIV). addr increments saturate at DEPTH-1 and never wrap.
// STRUCTURE
//  - clip_timer_pkg: state enum typedef (IDLE,RUN,DONE,HOLD), and a function
//    computing DIV/DEPTH/ADDR_W from the parameters.
//  - One sub-module: tick_divider (parameter DIV; inputs clock, reset_n, clear, run;
//    output tick). This holds the prescaler. clip_timer holds the FSM and the address counter.
// TESTING  (override CLK_HZ=40, SAMPLE_HZ=10, CLIP_SEC=2 -> DIV=4, DEPTH=20, ADDR_W=5)
//  1 reset_n=0 for 3 cycles with timer=1 -> all outputs 0, addr=0, busy=0 throughout.
//  2 timer high at E0 and held -> ticks at cycles 4,8,...,80 with addr 0..19.
//    seconds2 is high only at cycle 81. busy stays 1 until timer drops.
//  3 timer dropped right after the tick with addr=5 -> IDLE next edge, addr=0, busy=0,
//    and no seconds2 is ever seen.
//  4 timer held high for 10 cycles after seconds2 -> no ticks and no second seconds2.
//    Then timer low 1 cycle, high again -> fresh run, first tick addr=0 4 cycles later.
//  5 reset_n=0 for one edge mid-run at addr=10 -> IDLE, outputs 0. With timer still high,
//    a new run starts on the next edge with addr=0.
//  6 timer falls on the same edge as the final tick (addr=19) -> that tick is seen,
//    state goes to IDLE, and seconds2 stays 0.

Source files
------------

// File: rtl/clip_timer_pkg.sv
// Shared types and parameter derivation for the clip timer.
// Rate and clip-length arithmetic lives here so the top and the bench-facing ports agree.
package clip_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  typedef struct packed {
    int   div;
    int   depth;
    int   addr_w;
    logic ok;
  } clip_dims_t;

  // Guards against a zero sample rate so the division and modulo stay defined at elaboration.
  function automatic clip_dims_t clip_dims(input int clk_hz, input int sample_hz,
                                           input int clip_sec);
    clip_dims_t d;
    d.div    = (sample_hz > 0) ? clk_hz / sample_hz : 0;
    d.depth  = sample_hz * clip_sec;
    d.addr_w = (d.depth > 1) ? $clog2(d.depth) : 1;
    d.ok     = (sample_hz > 0) && (clk_hz > 0) && (clip_sec > 0) &&
               ((sample_hz > 0) ? (clk_hz % sample_hz == 0) : 1'b0) &&
               (d.div >= 2) && (d.depth >= 2);
    return d;
  endfunction

endpackage

// File: rtl/clip_timer_tick_divider.sv
// Sample-rate prescaler: registered one-cycle tick every DIV cycles of continuous run.
// Latency: first tick DIV edges after the edge that released clear; clear or !run zeroes it at once.
module tick_divider #(
  parameter int DIV = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int              PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]   LAST = PW'(DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;

  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (clear || !run) begin
      presc_d = '0;
    end else if (presc_q == LAST) begin
      presc_d = '0;
      tick_d  = 1'b1;
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/clip_timer.sv
// Clip timer: sample strobe + address generator, seconds2 pulse after DEPTH samples.
// Latency: first tick DIV cycles after timer is taken, seconds2 at DEPTH*DIV+1; no backpressure.
module clip_timer
  import clip_timer_pkg::*;
#(
  parameter  int         CLK_HZ    = 50_000_000,
  parameter  int         SAMPLE_HZ = 8_000,
  parameter  int         CLIP_SEC  = 2,
  localparam clip_dims_t DIMS      = clip_dims(CLK_HZ, SAMPLE_HZ, CLIP_SEC),
  localparam int         ADDR_W    = DIMS.addr_w
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              timer,
  output logic              sample_tick,
  output logic [ADDR_W-1:0] addr,
  output logic              seconds2,
  output logic              busy
);

  localparam int              DIV       = DIMS.div;
  localparam int              DEPTH     = DIMS.depth;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  if (!DIMS.ok) begin : g_bad_params
    $error("clip_timer: CLK_HZ must be a multiple of SAMPLE_HZ with DIV >= 2 and DEPTH >= 2");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              seconds2_q;
  logic              busy_q;
  logic              tick;

  // Prescaler only runs while RUN is held; an abort edge suppresses the tick it would have made.
  tick_divider #(
    .DIV (DIV)
  ) u_tick_divider (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (state_q != ST_RUN),
    .run     (timer),
    .tick    (tick)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      ST_IDLE: begin
        addr_d = '0;
        if (timer) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!timer) begin
          state_d = ST_IDLE;
          addr_d  = '0;
        end else if (tick) begin
          if (addr_q == LAST_ADDR) state_d = ST_DONE;
          else                     addr_d  = addr_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (timer) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_IDLE;
          addr_d  = '0;
        end
      end
      ST_HOLD: begin
        if (!timer) begin
          state_d = ST_IDLE;
          addr_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        addr_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      seconds2_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      seconds2_q <= (state_d == ST_DONE);
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  assign sample_tick = tick;
  assign addr        = addr_q;
  assign seconds2    = seconds2_q;
  assign busy        = busy_q;

endmodule
